dcache_mem_responder: RTL and testbench

DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

---
 rtl/dcache_mem_responder.sv | 100 ++++++++++
 tb/tb_dcache_mem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: fixed-latency line memory answering dcache line reads and writes
// Params: LINE_W line width (bits), DEPTH_LINES lines stored, LATENCY accept-to-ack cycles (1..15).
// Ports:  clk, rst_n (async, active low); dmem_sel_i, dcache2mem_{req,wr,addr,data,kill}_i request side;
//         mem2dcache_ack_o one-cycle completion pulse, mem2dcache_data_o read line, busy_o high in WAIT/ACK.
// Optional: define DMEM_KILL_EN to let dcache2mem_kill_i abort an in-flight request.
module dcache_mem_responder #(
  parameter int LINE_W      = 128,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmem_sel_i,
  input  logic              dcache2mem_req_i,
  input  logic              dcache2mem_wr_i,
  input  logic [31:0]       dcache2mem_addr_i,
  input  logic [LINE_W-1:0] dcache2mem_data_i,
  input  logic              dcache2mem_kill_i,
  output logic              mem2dcache_ack_o,
  output logic [LINE_W-1:0] mem2dcache_data_o,
  output logic              busy_o
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH_LINES);
`ifdef DMEM_KILL_EN
  localparam bit KILL_EN = 1'b1;
`else
  localparam bit KILL_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, ack_q, ack_d, busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d, in_idx;
  logic [LINE_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [LINE_W-1:0] mem [DEPTH_LINES];
  logic kill, accept, unused_addr;
  assign kill = KILL_EN && dcache2mem_kill_i;
  assign accept = dcache2mem_req_i && dmem_sel_i && !kill;
  assign in_idx = dcache2mem_addr_i[OFF_W +: IDX_W];
  assign unused_addr = ^{dcache2mem_addr_i[31:OFF_W+IDX_W], dcache2mem_addr_i[OFF_W-1:0]};
  // The read line is captured on the edge entering ACK, so data and ack appear together.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        wr_d = dcache2mem_wr_i;
        idx_d = in_idx;
        wdata_d = dcache2mem_data_i;
        cnt_d = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? ACK : WAIT;
        if (LATENCY == 1 && !dcache2mem_wr_i) rdata_d = mem[in_idx];
      end
      WAIT: begin
        cnt_d = kill ? 4'd0 : cnt_q - 4'd1;
        if (kill) state_d = IDLE;
        else if (cnt_q == 4'd1) begin
          state_d = ACK;
          if (!wr_q) rdata_d = mem[idx_q];
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d = state_d == ACK;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
    end
  end
  // Writes commit on the edge leaving ACK; a reset or kill before then drops them.
  always_ff @(posedge clk) begin
    if (state_q == ACK && wr_q && !kill) mem[idx_q] <= wdata_q;
  end
  assign mem2dcache_ack_o = ack_q;
  assign busy_o = busy_q;
  assign mem2dcache_data_o = rdata_q;
endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb_dcache_mem_responder: two responder instances (LATENCY 4 and 1) checked against a line-level model
module tb_dcache_mem_responder;
  localparam int LW = 128;
`ifdef DMEM_KILL_EN
  localparam bit KILL_EN = 1'b1;
`else
  localparam bit KILL_EN = 1'b0;
`endif
  localparam int LAT [2] = '{4, 1};
  localparam int DEP [2] = '{256, 16};
  typedef struct {
    int d;
    bit wr;
    logic [31:0] a;
    logic [LW-1:0] wd;
    int kill_at;
    bit keep;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel [2], req [2], wr_i [2], kill [2], ack [2], busy [2];
  logic [31:0] addr [2];
  logic [LW-1:0] wdata [2], rdata [2];
  logic [LW-1:0] mem_m [int];
  logic [LW-1:0] last_rd [2];
  bit hold_known [2];
  bit chain [2];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  dcache_mem_responder #(.LINE_W(LW), .DEPTH_LINES(256), .LATENCY(4)) u0 (
    .clk(clk), .rst_n(rst_n), .dmem_sel_i(sel[0]), .dcache2mem_req_i(req[0]),
    .dcache2mem_wr_i(wr_i[0]), .dcache2mem_addr_i(addr[0]), .dcache2mem_data_i(wdata[0]),
    .dcache2mem_kill_i(kill[0]), .mem2dcache_ack_o(ack[0]), .mem2dcache_data_o(rdata[0]),
    .busy_o(busy[0])
  );
  dcache_mem_responder #(.LINE_W(LW), .DEPTH_LINES(16), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .dmem_sel_i(sel[1]), .dcache2mem_req_i(req[1]),
    .dcache2mem_wr_i(wr_i[1]), .dcache2mem_addr_i(addr[1]), .dcache2mem_data_i(wdata[1]),
    .dcache2mem_kill_i(kill[1]), .mem2dcache_ack_o(ack[1]), .mem2dcache_data_o(rdata[1]),
    .busy_o(busy[1])
  );
  function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  // One transaction, called at a falling edge. Ack is expected on the LATENCY-th falling edge
  // after the accepting rising edge; keep leaves req high so the next call chains back-to-back.
  task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [LW-1:0] wd,
                     input int kill_at, input bit keep);
    int lat, got, key;
    bit killed;
    lat = LAT[d];
    got = 0;
    killed = KILL_EN && kill_at >= 1 && kill_at < lat;
    key = d * 4096 + int'((a / 16) % DEP[d]);
    sel[d] = 1'b1;
    req[d] = 1'b1;
    wr_i[d] = wr;
    addr[d] = a;
    wdata[d] = wd;
    if (chain[d]) @(posedge clk);
    @(posedge clk);
    for (int n = 1; n <= lat + 4 && got == 0; n++) begin
      @(negedge clk);
      kill[d] = 1'b0;
      if (n == 1) chk($sformatf("busy_after_accept_d%0d", d), LW'(busy[d]), LW'(1));
      if (ack[d]) got = n;
      else begin
        if (n == kill_at) begin
          kill[d] = 1'b1;
          req[d] = 1'b0;
        end
        addr[d] = $urandom;
        wdata[d] = {$urandom, $urandom, $urandom, $urandom};
        wr_i[d] = 1'($urandom);
      end
    end
    kill[d] = 1'b0;
    chk($sformatf("ack_latency_d%0d", d), LW'(got), LW'(killed ? 0 : lat));
    if (wr || killed) begin
      if (hold_known[d]) chk($sformatf("rdata_hold_d%0d", d), rdata[d], last_rd[d]);
      if (!killed) mem_m[key] = wd;
    end else if (mem_m.exists(key)) begin
      chk($sformatf("rdata_d%0d_a%h", d, a), rdata[d], mem_m[key]);
      last_rd[d] = mem_m[key];
      hold_known[d] = 1'b1;
    end else hold_known[d] = 1'b0;
    chain[d] = keep;
    if (!keep) begin
      req[d] = 1'b0;
      @(negedge clk);
      chk($sformatf("ack_pulse_d%0d", d), LW'(ack[d]), LW'(0));
      chk($sformatf("idle_busy_d%0d", d), LW'(busy[d]), LW'(0));
    end
  endtask
  task automatic idle(input int d);
    req[d] = 1'b0;
    chain[d] = 1'b0;
  endtask
  initial begin
    vec_t vt [$];
    logic [LW-1:0] aa, ff, ll, d1, d2, d3, lb;
    int bad;
    logic [31:0] ra;
    aa = {4{32'hAAAAAAAA}};
    ff = {4{32'h55555555}};
    d1 = {4{32'h11112222}};
    d2 = {4{32'h33334444}};
    d3 = {4{32'hDEADBEEF}};
    vt.push_back('{0, 1'b1, 32'h100, aa, 0, 1'b0});
    vt.push_back('{0, 1'b0, 32'h100, '0, 0, 1'b0});
    vt.push_back('{0, 1'b0, 32'h1100, '0, 0, 1'b0});
    vt.push_back('{0, 1'b0, 32'h10C, '0, 0, 1'b0});
    vt.push_back('{0, 1'b1, 32'h100, ff, 2, 1'b0});
    vt.push_back('{0, 1'b0, 32'h100, '0, 0, 1'b0});
    vt.push_back('{1, 1'b1, 32'h40, d1, 0, 1'b0});
    vt.push_back('{1, 1'b1, 32'h80, d2, 0, 1'b0});
    vt.push_back('{1, 1'b0, 32'h40, '0, 0, 1'b1});
    vt.push_back('{1, 1'b0, 32'h80, '0, 0, 1'b1});
    vt.push_back('{1, 1'b0, 32'h140, '0, 0, 1'b0});
    vt.push_back('{1, 1'b1, 32'h50, d3, 0, 1'b1});
    vt.push_back('{1, 1'b0, 32'h50, '0, 0, 1'b0});
    for (int d = 0; d < 2; d++) begin
      sel[d] = 1'b0; req[d] = 1'b0; wr_i[d] = 1'b0; kill[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; last_rd[d] = '0; hold_known[d] = 1'b1; chain[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ack_d%0d", d), LW'(ack[d]), LW'(0));
      chk($sformatf("reset_busy_d%0d", d), LW'(busy[d]), LW'(0));
      chk($sformatf("reset_rdata_d%0d", d), rdata[d], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    req[0] = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[0] || busy[0]) bad++;
    end
    chk("unselected_req_ignored", LW'(bad), LW'(0));
    req[0] = 1'b0;
    foreach (vt[i]) txn(vt[i].d, vt[i].wr, vt[i].a, vt[i].wd, vt[i].kill_at, vt[i].keep);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 30; i++) begin
        ra = $urandom;
        if (d == 0) ra[11:7] = '0;
        txn(d, 1'($urandom), ra, {$urandom, $urandom, $urandom, $urandom}, 0, i < 29 && $urandom_range(0, 2) == 0);
      end
      idle(d);
    end
    lb = {4{32'hCAFEF00D}};
    txn(0, 1'b1, 32'h300, d2, 0, 1'b0);
    sel[0] = 1'b1; req[0] = 1'b1; wr_i[0] = 1'b1; addr[0] = 32'h300; wdata[0] = lb;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_reset", LW'(busy[0]), LW'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_ack", LW'(ack[0]), LW'(0));
    chk("async_reset_busy", LW'(busy[0]), LW'(0));
    chk("async_reset_rdata", rdata[0], '0);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = '0; hold_known[d] = 1'b1; chain[d] = 1'b0;
    end
    @(negedge clk);
    txn(0, 1'b0, 32'h300, '0, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
